// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back stage: selects load vs ALU data, drives the RF write port, counts retirements.
// Optional WB-stage forwarding outputs are enabled by defining WB_FWD_EN.
module mem_wb_writeback #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_ex_mem,
  input  logic                  ctrl_regWrite_ex_mem,
  input  logic                  ctrl_memToReg_ex_mem,
  input  logic [DATA_W-1:0]     alu_result_ex_mem,
  input  logic [REG_ADDR_W-1:0] write_reg_ex_mem,
  input  logic [DATA_W-1:0]     read_data_from_mem,
`ifdef WB_FWD_EN
  input  logic [REG_ADDR_W-1:0] fwd_rs_addr,
  input  logic [REG_ADDR_W-1:0] fwd_rt_addr,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit,
  output logic [DATA_W-1:0]     fwd_data,
`endif
  output logic                  valid_mem_wb,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [CNT_W-1:0]      retired_count
);

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [CNT_W-1:0]      retired_count_q, retired_count_d;
  logic                  commit_s;
  logic                  rf_we_s;
  logic [DATA_W-1:0]     rf_wdata_s;

  // Next-state for the MEM/WB register: flush beats stall, stall beats capture.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_d        = alu_q;
    rf_waddr_d   = rf_waddr_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall) begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
    end else begin
      valid_d      = valid_ex_mem;
      reg_write_d  = ctrl_regWrite_ex_mem;
      mem_to_reg_d = ctrl_memToReg_ex_mem;
      alu_d        = alu_result_ex_mem;
      rf_waddr_d   = write_reg_ex_mem;
    end
  end

  // Commit and write-back datapath; a flush in the same cycle does not stop the current WB instruction.
  always_comb begin
    commit_s   = valid_q & ~stall;
    rf_we_s    = commit_s & reg_write_q & (rf_waddr_q != {REG_ADDR_W{1'b0}});
    if (mem_to_reg_q) begin
      rf_wdata_s = read_data_from_mem;
    end else begin
      rf_wdata_s = alu_q;
    end
    if (commit_s) begin
      retired_count_d = retired_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_count_d = retired_count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      alu_q           <= {DATA_W{1'b0}};
      rf_waddr_q      <= {REG_ADDR_W{1'b0}};
      retired_count_q <= {CNT_W{1'b0}};
    end else begin
      valid_q         <= valid_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      alu_q           <= alu_d;
      rf_waddr_q      <= rf_waddr_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign valid_mem_wb  = valid_q;
  assign rf_we         = rf_we_s;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_s;
  assign retired_count = retired_count_q;

`ifdef WB_FWD_EN
  assign fwd_rs_hit = rf_we_s & (rf_waddr_q == fwd_rs_addr);
  assign fwd_rt_hit = rf_we_s & (rf_waddr_q == fwd_rt_addr);
  assign fwd_data   = rf_wdata_s;
`endif

endmodule
